pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
Parametrised program-counter generator for the yadan core front end, superseding the fixed 32-bit free-running PC.
- Issues fetch addresses over a req/gnt handshake to the CPU bus interface; address is held stable while a request is outstanding.
- Applies trap and branch redirects with fixed priority, latching a redirect that arrives mid-handshake.
- Reports each granted fetch to IF/ID with a valid/kill qualifier.

Parameters:
ADDR_W, 32, address/PC width in bits
START_ADDR, 32'h0000_0000, reset PC and wrap target
END_ADDR, 32'h0000_3FFC, last sequential fetch address before wrap
STEP, 4, sequential increment in bytes; legal values 2 or 4

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
fetch_en_i  input  1  global fetch enable from mem stage
stall_i  input  1  IF stall from ctrl; blocks issue of new requests
trap_flag_i  input  1  trap/exception redirect, highest priority
trap_addr_i  input  ADDR_W  trap vector
ex_branch_flag_i  input  1  branch/jump redirect from ex
ex_branch_addr_i  input  ADDR_W  branch target
req_o  output  1  fetch request to bus interface
addr_o  output  ADDR_W  fetch address; stable while req_o && !gnt_i
gnt_i  input  1  bus accepted current request this cycle
pc_o  output  ADDR_W  address of last granted fetch, to if_id
pc_valid_o  output  1  one-cycle pulse: pc_o is a live (not killed) fetch

Behaviour:
- Clock and reset: clk; reset rst is asynchronous, active-low.
- Reset values: state=IDLE, req_o=0, addr_o=START_ADDR, pc_o=START_ADDR, pc_valid_o=0, pending redirect cleared.
- Redirect source: trap_flag_i > ex_branch_flag_i; a trap and a branch in the same cycle select the trap.
- FSM state IDLE (req_o=0):
  - Active redirect loads addr_o directly next cycle.
  - Go to REQ when fetch_en_i && !stall_i.
- FSM state REQ (req_o=1), handshake:
  - addr_o is held while gnt_i=0.
  - A redirect in this window is stored in pend_vld/pend_addr.
  - A trap overwrites a pending branch; a branch never overwrites a pending trap; a newer same-class redirect overwrites.
- On gnt_i=1, next addr_o, first match wins:
  - redirect this cycle
  - pending redirect (then cleared)
  - START_ADDR if addr_o >= END_ADDR
  - addr_o+STEP, truncated to ADDR_W
- After a grant: stay in REQ if fetch_en_i && !stall_i, else go to IDLE.
- In REQ, stall_i or a low fetch_en_i never drops req_o before gnt_i.
- pc_o/pc_valid_o, 1-cycle latency after gnt_i:
  - pc_o <= granted addr_o.
  - pc_valid_o <= 1 unless a redirect is active that cycle or pend_vld=1 (fetch killed).
  - pc_o holds its value otherwise; pc_valid_o=0 when no grant.
- Redirect in IDLE with fetch_en_i=0 is still applied; a redirect wins over stall.
- Reset mid-handshake: req_o drops immediately (async), pending redirect discarded.
- Redirect low bits below log2(STEP) are forced to zero (unless the option below is enabled).

Optional Feature:
Macro PCGEN_MISALIGN_CHK_EN.
- Defined:
  - Extra outputs misalign_o (1) and misalign_addr_o (ADDR_W).
  - A redirect target with nonzero bits below log2(STEP) is not applied and not latched.
  - misalign_o pulses for one cycle the cycle after the redirect; misalign_addr_o holds the bad target until the next misalign event; reset 0.
  - A valid lower-priority redirect in the same cycle is also dropped.
- Undefined: ports absent; low bits silently masked as described in Behaviour.

Test Plan:
- Reset release, fetch_en_i=1, gnt_i=1 every cycle -> addr_o 0x0,0x4,0x8...; pc_valid_o pulses with pc_o lagging addr_o by one cycle.
- Sequence reaches 0x3FFC, gnt_i=1 -> next addr_o=0x0000_0000; pc_o=0x3FFC valid.
- req_o=1 at 0x10, gnt_i=0 for 3 cycles, branch to 0x200 in cycle 1 -> addr_o holds 0x10; on grant pc_o=0x10 with pc_valid_o=0; next addr_o=0x200.
- Same cycle trap_addr_i=0x80 and ex_branch_addr_i=0x200 with gnt_i=1 -> addr_o=0x80; pending branch ignored; granted fetch killed.
- stall_i=1 while req_o=1, gnt_i=0 -> req_o stays 1 until grant, then 0; stall_i low -> req_o=1 next cycle at addr+4.
- PCGEN_MISALIGN_CHK_EN, STEP=4, branch to 0x102 -> misalign_o=1 for one cycle, misalign_addr_o=0x102, addr_o continues sequentially.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: issues fetch addresses over req/gnt, applies trap/branch redirects, reports granted fetches.
// Optional macro PCGEN_MISALIGN_CHK_EN: reject and report redirect targets not aligned to STEP instead of masking them.
module pc_gen #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    START_ADDR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]    END_ADDR   = 32'h0000_3FFC,
    parameter int unsigned          STEP       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en_i,
    input  logic              stall_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              ex_branch_flag_i,
    input  logic [ADDR_W-1:0] ex_branch_addr_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic              gnt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o
`ifdef PCGEN_MISALIGN_CHK_EN
    ,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o
`endif
);

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] STEP_W   = ADDR_W'(STEP);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state;
    logic              pend_vld;
    logic              pend_trap;
    logic [ADDR_W-1:0] pend_addr;

    logic              sel_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic              redir_vld;
    logic              redir_trap;
    logic [ADDR_W-1:0] redir_addr;
    logic              go;
    logic [ADDR_W-1:0] seq_addr;

    assign sel_vld    = trap_flag_i | ex_branch_flag_i;
    assign sel_addr   = trap_flag_i ? trap_addr_i : ex_branch_addr_i;
    assign redir_trap = trap_flag_i;
    assign go         = fetch_en_i & ~stall_i;
    assign seq_addr   = (addr_o >= END_ADDR) ? START_ADDR : addr_o + STEP_W;

`ifdef PCGEN_MISALIGN_CHK_EN
    logic sel_bad;

    // A misaligned winner suppresses the whole redirect, including any lower-priority source.
    assign sel_bad    = sel_vld & (|(sel_addr & LOW_MASK));
    assign redir_vld  = sel_vld & ~sel_bad;
    assign redir_addr = sel_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            misalign_o <= sel_bad;
            if (sel_bad) begin
                misalign_addr_o <= sel_addr;
            end
        end
    end
`else
    assign redir_vld  = sel_vld;
    assign redir_addr = sel_addr & ~LOW_MASK;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_o      <= 1'b0;
            addr_o     <= START_ADDR;
            pc_o       <= START_ADDR;
            pc_valid_o <= 1'b0;
            pend_vld   <= 1'b0;
            pend_trap  <= 1'b0;
            pend_addr  <= START_ADDR;
        end else begin
            pc_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (redir_vld) begin
                        addr_o <= redir_addr;
                    end
                    if (go) begin
                        state <= REQ;
                        req_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (!gnt_i) begin
                        // Address must stay put mid-handshake, so redirects wait in the pending slot.
                        if (redir_vld && (!pend_vld || redir_trap || !pend_trap)) begin
                            pend_vld  <= 1'b1;
                            pend_trap <= redir_trap;
                            pend_addr <= redir_addr;
                        end
                    end else begin
                        pc_o       <= addr_o;
                        pc_valid_o <= ~(redir_vld | pend_vld);
                        if (redir_vld) begin
                            addr_o <= redir_addr;
                        end else if (pend_vld) begin
                            addr_o <= pend_addr;
                        end else begin
                            addr_o <= seq_addr;
                        end
                        pend_vld  <= 1'b0;
                        pend_trap <= 1'b0;
                        if (!go) begin
                            state <= IDLE;
                            req_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios then random traffic, checked every cycle against a behavioural model.
module tb_pc_gen;

    localparam logic [31:0] START = 32'h0000_0000;
    localparam logic [31:0] END_A = 32'h0000_3FFC;
    localparam int unsigned STEP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en_i, stall_i, trap_flag_i, ex_branch_flag_i, gnt_i;
    logic [31:0] trap_addr_i, ex_branch_addr_i;
    logic        req_o, pc_valid_o;
    logic [31:0] addr_o, pc_o;
`ifdef PCGEN_MISALIGN_CHK_EN
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state.
    logic        m_req, m_pcv, m_pv, m_ptrap;
    logic [31:0] m_addr, m_pc, m_paddr;
    logic        m_mis;
    logic [31:0] m_mis_addr;

    pc_gen dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en_i       (fetch_en_i),
        .stall_i          (stall_i),
        .trap_flag_i      (trap_flag_i),
        .trap_addr_i      (trap_addr_i),
        .ex_branch_flag_i (ex_branch_flag_i),
        .ex_branch_addr_i (ex_branch_addr_i),
        .req_o            (req_o),
        .addr_o           (addr_o),
        .gnt_i            (gnt_i),
        .pc_o             (pc_o),
        .pc_valid_o       (pc_valid_o)
`ifdef PCGEN_MISALIGN_CHK_EN
        ,
        .misalign_o       (misalign_o),
        .misalign_addr_o  (misalign_addr_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_addr = START; m_pc = START; m_pcv = 1'b0;
        m_pv = 1'b0; m_ptrap = 1'b0; m_paddr = START;
        m_mis = 1'b0; m_mis_addr = 32'h0;
    endtask

    // One clock of the spec's rules, evaluated from the inputs present at the edge.
    task automatic model_tick();
        logic        sel, red;
        logic [31:0] tgt;
        sel = trap_flag_i | ex_branch_flag_i;
        tgt = trap_flag_i ? trap_addr_i : ex_branch_addr_i;
`ifdef PCGEN_MISALIGN_CHK_EN
        m_mis = sel && (tgt % STEP != 0);
        if (m_mis) m_mis_addr = tgt;
        red = sel && !m_mis;
`else
        red = sel;
        tgt = tgt - (tgt % STEP);
`endif
        m_pcv = 1'b0;
        if (!m_req) begin
            if (red) m_addr = tgt;
            m_req = fetch_en_i && !stall_i;
        end else if (!gnt_i) begin
            if (red && (!m_pv || trap_flag_i || !m_ptrap)) begin
                m_pv = 1'b1; m_paddr = tgt; m_ptrap = trap_flag_i;
            end
        end else begin
            m_pc  = m_addr;
            m_pcv = !(red || m_pv);
            if (red)              m_addr = tgt;
            else if (m_pv)        m_addr = m_paddr;
            else if (m_addr >= END_A) m_addr = START;
            else                  m_addr = m_addr + STEP;
            m_pv  = 1'b0;
            m_req = fetch_en_i && !stall_i;
        end
    endtask

    task automatic compare_all();
        chk("req_o", {31'h0, req_o}, {31'h0, m_req});
        chk("addr_o", addr_o, m_addr);
        chk("pc_o", pc_o, m_pc);
        chk("pc_valid_o", {31'h0, pc_valid_o}, {31'h0, m_pcv});
`ifdef PCGEN_MISALIGN_CHK_EN
        chk("misalign_o", {31'h0, misalign_o}, {31'h0, m_mis});
        chk("misalign_addr_o", misalign_addr_o, m_mis_addr);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
    endtask

    task automatic clear_redir();
        trap_flag_i = 1'b0; ex_branch_flag_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; fetch_en_i = 1'b0; stall_i = 1'b0; gnt_i = 1'b0;
        trap_flag_i = 1'b0; trap_addr_i = 32'h0;
        ex_branch_flag_i = 1'b0; ex_branch_addr_i = 32'h0;
        model_reset();
        #12;
        chk("rst_req", {31'h0, req_o}, 32'h0);
        chk("rst_addr", addr_o, START);
        chk("rst_pc", pc_o, START);
        chk("rst_pcv", {31'h0, pc_valid_o}, 32'h0);
        #1 rst = 1'b1;

        // Free-running sequential fetch with continuous grants.
        fetch_en_i = 1'b1; gnt_i = 1'b1;
        step();
        chk("first_req", {31'h0, req_o}, 32'h1);
        step();
        chk("seq_addr", addr_o, 32'h4);
        chk("seq_pc", pc_o, 32'h0);
        chk("seq_pcv", {31'h0, pc_valid_o}, 32'h1);
        repeat (3) step();

        // Wrap at END_ADDR.
        ex_branch_flag_i = 1'b1; ex_branch_addr_i = 32'h3FF8;
        step();
        clear_redir();
        step();
        step();
        chk("wrap_addr", addr_o, 32'h0);
        chk("wrap_pc", pc_o, 32'h3FFC);
        chk("wrap_pcv", {31'h0, pc_valid_o}, 32'h1);

        // Branch arriving mid-handshake is held until grant and kills the granted fetch.
        ex_branch_flag_i = 1'b1; ex_branch_addr_i = 32'h10;
        step();
        gnt_i = 1'b0; ex_branch_addr_i = 32'h200;
        step();
        clear_redir();
        step();
        step();
        chk("hold_addr", addr_o, 32'h10);
        gnt_i = 1'b1;
        step();
        chk("pend_pc", pc_o, 32'h10);
        chk("pend_kill", {31'h0, pc_valid_o}, 32'h0);
        chk("pend_addr", addr_o, 32'h200);

        // Trap and branch together beat an older pending branch.
        gnt_i = 1'b0; ex_branch_flag_i = 1'b1; ex_branch_addr_i = 32'h300;
        step();
        gnt_i = 1'b1; trap_flag_i = 1'b1; trap_addr_i = 32'h80; ex_branch_addr_i = 32'h200;
        step();
        chk("trap_addr", addr_o, 32'h80);
        chk("trap_kill", {31'h0, pc_valid_o}, 32'h0);
        clear_redir();
        step();
        chk("trap_next", addr_o, 32'h84);
        chk("trap_pcv", {31'h0, pc_valid_o}, 32'h1);

        // Stall does not drop an outstanding request.
        gnt_i = 1'b0; stall_i = 1'b1;
        step();
        step();
        chk("stall_hold_req", {31'h0, req_o}, 32'h1);
        gnt_i = 1'b1;
        step();
        chk("stall_drop_req", {31'h0, req_o}, 32'h0);
        step();
        stall_i = 1'b0;
        step();
        chk("stall_resume_req", {31'h0, req_o}, 32'h1);
        chk("stall_resume_addr", addr_o, 32'h88);

`ifdef PCGEN_MISALIGN_CHK_EN
        ex_branch_flag_i = 1'b1; ex_branch_addr_i = 32'h102;
        step();
        chk("mis_pulse", {31'h0, misalign_o}, 32'h1);
        chk("mis_addr", misalign_addr_o, 32'h102);
        chk("mis_seq", addr_o, 32'h8C);
        clear_redir();
        step();
        chk("mis_clear", {31'h0, misalign_o}, 32'h0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            fetch_en_i       = ($urandom_range(0, 7) != 0);
            stall_i          = ($urandom_range(0, 4) == 0);
            gnt_i            = ($urandom_range(0, 1) == 1);
            trap_flag_i      = ($urandom_range(0, 15) == 0);
            ex_branch_flag_i = ($urandom_range(0, 7) == 0);
            trap_addr_i      = $urandom_range(0, 32'h4FFF);
            ex_branch_addr_i = $urandom_range(0, 32'h4FFF);
            step();
        end

        // Asynchronous reset in the middle of a handshake.
        clear_redir();
        fetch_en_i = 1'b1; stall_i = 1'b0; gnt_i = 1'b0;
        ex_branch_flag_i = 1'b1; ex_branch_addr_i = 32'h40;
        step();
        clear_redir();
        step();
        ex_branch_flag_i = 1'b1; ex_branch_addr_i = 32'h500;
        step();
        clear_redir();
        rst = 1'b0;
        #1;
        chk("arst_req", {31'h0, req_o}, 32'h0);
        chk("arst_addr", addr_o, START);
        model_reset();
        #2 rst = 1'b1;
        gnt_i = 1'b1;
        step();
        step();
        chk("post_rst_addr", addr_o, 32'h4);
        chk("post_rst_pcv", {31'h0, pc_valid_o}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
